// File: rtl/trainerror_hs_module.sv
// Initiator side of the TRAINERROR entry sideband handshake: drives REQ (4'hF), waits for RESP (4'hE).
// Outputs registered from next state; REQ held until TX busy falls; TRAINERROR_RETRY_EN adds REQ retries.
module trainerror_hs_module #(
  parameter int SB_MSG_WIDTH   = 4,
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int MAX_RETRY      = 1
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_trainerror_en,
  input  logic                    i_msg_valid,
  input  logic [SB_MSG_WIDTH-1:0] i_Rx_SbMessage,
  input  logic                    i_falling_edge_busy,
  input  logic                    i_partner_valid,
  output logic [SB_MSG_WIDTH-1:0] o_TX_SbMessage,
  output logic                    o_valid_Module,
  output logic                    o_trainerror_end_Module,
  output logic                    o_timeout
);
  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [SB_MSG_WIDTH-1:0] MSG_REQ  = SB_MSG_WIDTH'(4'hF);
  localparam logic [SB_MSG_WIDTH-1:0] MSG_RESP = SB_MSG_WIDTH'(4'hE);
  localparam logic [CW-1:0]           CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE                    = 3'd0,
    WAIT_BUSY_CLEAR_FOR_REQ = 3'd1,
    SEND_REQ                = 3'd2,
    WAIT_FOR_RESP           = 3'd3,
    TEST_COMPLETE           = 3'd4,
    TIMEOUT                 = 3'd5
  } state_t;

  state_t        state, ns;
  logic [CW-1:0] cnt;
  logic          resp_seen;
  logic          resp_now;
  logic          expired;
  logic          retry_ok;

  assign resp_now = i_msg_valid && (i_Rx_SbMessage == MSG_RESP);
  assign expired  = (cnt >= CNT_LAST);

`ifdef TRAINERROR_RETRY_EN
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  logic [RW-1:0] retry_cnt;
  logic          retry_take;

  assign retry_ok   = (retry_cnt < RW'(MAX_RETRY));
  assign retry_take = ((state == SEND_REQ) || (state == WAIT_FOR_RESP)) &&
                      (ns == WAIT_BUSY_CLEAR_FOR_REQ);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)         retry_cnt <= '0;
    else if (ns == IDLE)  retry_cnt <= '0;
    else if (retry_take)  retry_cnt <= retry_cnt + 1'b1;
  end
`else
  // Retry not built: never true for any legal (non-negative) MAX_RETRY.
  assign retry_ok = (MAX_RETRY < 0);
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= ns;
  end

  always_comb begin
    ns = state;
    case (state)
      IDLE:                    if (i_trainerror_en) ns = WAIT_BUSY_CLEAR_FOR_REQ;
      WAIT_BUSY_CLEAR_FOR_REQ: if (!i_partner_valid) ns = SEND_REQ;
      SEND_REQ: begin
        // A response (early or current) beats both the busy pulse and expiry.
        if ((resp_seen || resp_now) && (i_falling_edge_busy || expired)) ns = TEST_COMPLETE;
        else if (expired)             ns = retry_ok ? WAIT_BUSY_CLEAR_FOR_REQ : TIMEOUT;
        else if (i_falling_edge_busy) ns = WAIT_FOR_RESP;
      end
      WAIT_FOR_RESP: begin
        if (resp_now)     ns = TEST_COMPLETE;
        else if (expired) ns = retry_ok ? WAIT_BUSY_CLEAR_FOR_REQ : TIMEOUT;
      end
      TEST_COMPLETE,
      TIMEOUT:                 ns = state;
      default:                 ns = IDLE;
    endcase
    if ((state != IDLE) && !i_trainerror_en) ns = IDLE;
  end

  // Window counter restarts whenever a (re)send is armed; it only runs while REQ is outstanding.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt <= '0;
    end else if ((ns == IDLE) || (ns == WAIT_BUSY_CLEAR_FOR_REQ)) begin
      cnt <= '0;
    end else if (((state == SEND_REQ) || (state == WAIT_FOR_RESP)) && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                          resp_seen <= 1'b0;
    else if (ns == IDLE)                   resp_seen <= 1'b0;
    else if ((state == SEND_REQ) && resp_now) resp_seen <= 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_TX_SbMessage          <= '0;
      o_valid_Module          <= 1'b0;
      o_trainerror_end_Module <= 1'b0;
      o_timeout               <= 1'b0;
    end else begin
      o_TX_SbMessage          <= (ns == SEND_REQ) ? MSG_REQ : '0;
      o_valid_Module          <= (ns == SEND_REQ);
      o_trainerror_end_Module <= (ns == TEST_COMPLETE);
      o_timeout               <= (ns == TIMEOUT);
    end
  end
endmodule

// File: tb/tb_trainerror_hs_module.sv
// Bench for trainerror_hs_module: directed handshake scenarios plus randomized traffic against a behavioural model.
module tb_trainerror_hs_module;
  localparam int TC = 16;
  localparam int MR = 1;
`ifdef TRAINERROR_RETRY_EN
  localparam bit RETRY = 1'b1;
`else
  localparam bit RETRY = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       en = 1'b0, msg_valid = 1'b0, busy = 1'b0, pv = 1'b0;
  logic [3:0] rx = 4'h0;
  logic [3:0] tx;
  logic       vld, done, tout;

  int total = 0;
  int bad = 0;
  bit check_en = 1'b0;

  always #5 clk = ~clk;

  trainerror_hs_module #(.SB_MSG_WIDTH(4), .TIMEOUT_CYCLES(TC), .MAX_RETRY(MR)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_trainerror_en(en), .i_msg_valid(msg_valid),
    .i_Rx_SbMessage(rx), .i_falling_edge_busy(busy), .i_partner_valid(pv),
    .o_TX_SbMessage(tx), .o_valid_Module(vld), .o_trainerror_end_Module(done), .o_timeout(tout)
  );

  // Model: where the handshake stands, how long the current REQ window has run,
  // whether a RESP already arrived while REQ was on the wire, and how many resends were used.
  localparam int P_IDLE = 0, P_ARM = 1, P_REQ = 2, P_AWAIT = 3, P_DONE = 4, P_FAIL = 5;
  int m_phase = P_IDLE;
  int m_elapsed = 0;
  bit m_early = 1'b0;
  int m_tries = 0;

  always @(posedge clk or negedge rst_n) begin
    bit resp, expired, finished;
    if (!rst_n) begin
      m_phase = P_IDLE; m_elapsed = 0; m_early = 1'b0; m_tries = 0;
    end else if (m_phase != P_IDLE && !en) begin
      m_phase = P_IDLE; m_elapsed = 0; m_early = 1'b0; m_tries = 0;
    end else begin
      resp = msg_valid && (rx == 4'hE);
      case (m_phase)
        P_IDLE: if (en) m_phase = P_ARM;
        P_ARM:  if (!pv) m_phase = P_REQ;
        P_REQ, P_AWAIT: begin
          expired = (m_elapsed >= TC - 1);
          if (m_phase == P_REQ) begin
            if (resp) m_early = 1'b1;
            finished = m_early && (busy || expired);
          end else begin
            finished = resp;
          end
          if (finished) m_phase = P_DONE;
          else if (expired) begin
            if (RETRY && m_tries < MR) begin
              m_tries++; m_elapsed = 0; m_phase = P_ARM;
            end else m_phase = P_FAIL;
          end else begin
            m_elapsed++;
            if (m_phase == P_REQ && busy) m_phase = P_AWAIT;
          end
        end
        default: ;
      endcase
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      chk("cyc_tx",   tx,   (m_phase == P_REQ) ? 4'hF : 4'h0);
      chk("cyc_vld",  vld,  m_phase == P_REQ);
      chk("cyc_end",  done, m_phase == P_DONE);
      chk("cyc_tout", tout, m_phase == P_FAIL);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic sel(input int which);
    case (which)
      0: return vld;
      1: return done;
      default: return tout;
    endcase
  endfunction

  task automatic wait_for(input int which, input int budget, output int cycles);
    cycles = 0;
    while (!sel(which) && cycles < budget) begin
      tick();
      cycles++;
    end
  endtask

  task automatic go_idle();
    en = 1'b0; pv = 1'b0; busy = 1'b0; msg_valid = 1'b0;
    tick(); tick();
  endtask

  task automatic start_req(input string name);
    int c;
    en = 1'b1;
    wait_for(0, 20, c);
    chk(name, c, 2);
  endtask

  task automatic pulse_busy();
    busy = 1'b1; tick(); busy = 1'b0;
  endtask

  task automatic send_msg(input logic [3:0] m);
    msg_valid = 1'b1; rx = m; tick(); msg_valid = 1'b0; rx = 4'h0;
  endtask

  initial begin
    int c;
    #1 rst_n = 1'b0;
    tick(); tick();
    check_en = 1'b1;
    chk("reset_vld", vld, 0);
    chk("reset_tx", tx, 0);
    rst_n = 1'b1;
    tick();

    // Basic handshake
    start_req("basic_req_latency");
    chk("basic_tx", tx, 4'hF);
    pulse_busy();
    repeat (5) tick();
    send_msg(4'hE);
    chk("basic_end", done, 1);
    chk("basic_vld_off", vld, 0);
    chk("basic_tx_off", tx, 0);
    go_idle();

    // Partner owns TX path
    pv = 1'b1; en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("collide_vld_held", vld, 0);
    end
    pv = 1'b0;
    tick();
    chk("collide_req_next", vld, 1);
    go_idle();

    // Early response before busy pulse
    start_req("early_req_latency");
    send_msg(4'hE);
    chk("early_still_req", vld, 1);
    tick(); tick();
    pulse_busy();
    chk("early_end", done, 1);
    chk("early_no_tout", tout, 0);
    go_idle();

    // Wrong messages ignored
    start_req("wrong_req_latency");
    pulse_busy();
    send_msg(4'hF);
    send_msg(4'h3);
    chk("wrong_no_end", done, 0);
    send_msg(4'hE);
    chk("wrong_then_end", done, 1);
    go_idle();

    // Abort mid-wait, then fresh timeout window
    start_req("abort_req_latency");
    pulse_busy();
    repeat (8) tick();
    en = 1'b0;
    tick();
    chk("abort_vld", vld, 0);
    chk("abort_end", done, 0);
    chk("abort_tout", tout, 0);
    start_req("timeout_req_latency");
    wait_for(2, 100, c);
    chk("timeout_cycles", c, RETRY ? (2 * TC + 1) : TC);
    go_idle();

    // Async reset while REQ is driven
    start_req("arst_req_latency");
    #2 rst_n = 1'b0;
    #1;
    chk("arst_vld", vld, 0);
    chk("arst_tx", tx, 0);
    tick();
    rst_n = 1'b1;
    go_idle();

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      int seg;
      seg = i / 500;
      en = ($urandom_range(99) < ((seg % 2 != 0) ? 97 : 99));
      pv = ($urandom_range(99) < 25);
      busy = ($urandom_range(99) < ((seg % 3 == 0) ? 5 : 20));
      msg_valid = ($urandom_range(99) < 15);
      case ($urandom_range(3))
        0: rx = 4'hE;
        1: rx = 4'hF;
        2: rx = 4'h3;
        default: rx = 4'($urandom_range(15));
      endcase
      tick();
    end
    go_idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
